lut_ram_mp: RTL and testbench

//  Multi-read-port, byte-writable LUT RAM. Generalises the single-port lut_ram.

---
 rtl/lut_ram_pkg.sv | 10 +
 rtl/riscv_32i_defs_pkg.sv | 4 +
 rtl/lut_ram_clear_fsm.sv | 60 ++++++
 rtl/lut_ram_mp.sv | 75 +++++++
 tb/tb_lut_ram_mp.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/lut_ram_pkg.sv
// Shared types and helpers for the multi-port LUT RAM and its clear sequencer.
package lut_ram_pkg;
  typedef enum logic {LR_IDLE, LR_CLR} lut_ram_state_e;

  function automatic logic [7:0] byte_merge(input logic [7:0] old_b,
                                            input logic [7:0] new_b,
                                            input logic       mask);
    return mask ? new_b : old_b;
  endfunction
endpackage

// File: rtl/riscv_32i_defs_pkg.sv
// Core-wide architectural constants for the RV32I pipeline.
package riscv_32i_defs_pkg;
  localparam int XLEN = 32;
endpackage

// File: rtl/lut_ram_clear_fsm.sv
// Clear sequencer: walks every entry once after reset or on clear_req.
// Latency: LUT_DEPTH cycles of busy per clear; clear_req is ignored while busy.
// Backpressure: busy blocks user writes at the array.
module lut_ram_clear_fsm
  import lut_ram_pkg::*;
#(
  parameter int LUT_DEPTH = 256,
  parameter int ADDR_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_req,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LUT_DEPTH - 1);

  lut_ram_state_e    state, state_nxt;
  logic [ADDR_W-1:0] clr_addr_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= LR_CLR;
      clr_addr <= '0;
    end else begin
      state    <= state_nxt;
      clr_addr <= clr_addr_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    clr_addr_nxt = clr_addr;
    case (state)
      LR_CLR: begin
        if (clr_addr == LAST_ADDR) begin
          state_nxt    = LR_IDLE;
          clr_addr_nxt = '0;
        end else begin
          clr_addr_nxt = clr_addr + 1'b1;
        end
      end
      LR_IDLE: begin
        if (clear_req) begin
          state_nxt    = LR_CLR;
          clr_addr_nxt = '0;
        end
      end
      default: state_nxt = LR_CLR;
    endcase
  end

  always_comb begin
    busy   = (state == LR_CLR);
    clr_we = (state == LR_CLR);
  end

endmodule

// File: rtl/lut_ram_mp.sv
// Byte-writable LUT RAM, NUM_RD_PORTS async reads, hardware clear; LUT_RAM_WR_BYPASS_EN selects write-first reads.
// Latency: reads combinational, writes commit at the rising edge.
// Backpressure: writes dropped and reads return zero while busy.
module lut_ram_mp
  import lut_ram_pkg::*;
#(
  parameter int   LUT_WIDTH    = riscv_32i_defs_pkg::XLEN,
  parameter int   LUT_DEPTH    = 256,
  parameter int   NUM_RD_PORTS = 2,
  localparam int  ADDR_W       = (LUT_DEPTH > 1) ? $clog2(LUT_DEPTH) : 1,
  localparam int  NUM_BYTES    = LUT_WIDTH / 8
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   clear_req,
  output logic                                   busy,
  input  logic                                   wr_en,
  input  logic [NUM_BYTES-1:0]                   wr_byte_en,
  input  logic [ADDR_W-1:0]                      wr_addr,
  input  logic [LUT_WIDTH-1:0]                   wr_data,
  input  logic [NUM_RD_PORTS-1:0][ADDR_W-1:0]    rd_addr,
  output logic [NUM_RD_PORTS-1:0][LUT_WIDTH-1:0] rd_data
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(LUT_DEPTH);

  logic [LUT_WIDTH-1:0] mem [LUT_DEPTH];
  logic                 clr_we;
  logic [ADDR_W-1:0]    clr_addr;
  logic                 wr_ok;

  lut_ram_clear_fsm #(
    .LUT_DEPTH (LUT_DEPTH),
    .ADDR_W    (ADDR_W)
  ) u_clear_fsm (
    .clk       (clk),
    .rst       (rst),
    .clear_req (clear_req),
    .busy      (busy),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr)
  );

  assign wr_ok = wr_en && !busy && ({1'b0, wr_addr} < DEPTH_C);

  // Clear owns the write port for its whole run, so no arbitration beyond priority.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (wr_ok) begin
      for (int b = 0; b < NUM_BYTES; b++) begin
        mem[wr_addr][8*b +: 8] <= byte_merge(mem[wr_addr][8*b +: 8],
                                             wr_data[8*b +: 8], wr_byte_en[b]);
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int p = 0; p < NUM_RD_PORTS; p++) begin
      if (!busy && ({1'b0, rd_addr[p]} < DEPTH_C)) begin
        rd_data[p] = mem[rd_addr[p]];
`ifdef LUT_RAM_WR_BYPASS_EN
        if (wr_en && (rd_addr[p] == wr_addr)) begin
          for (int b = 0; b < NUM_BYTES; b++) begin
            rd_data[p][8*b +: 8] = byte_merge(rd_data[p][8*b +: 8],
                                              wr_data[8*b +: 8], wr_byte_en[b]);
          end
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_lut_ram_mp.sv
// Directed bench for lut_ram_mp against a byte-mask/clear reference model and scoreboard.
module tb_lut_ram_mp;
  localparam int W  = 32;
  localparam int D  = 256;
  localparam int NP = 2;
  localparam int AW = 8;
`ifdef LUT_RAM_WR_BYPASS_EN
  localparam logic [31:0] RW_PRE = 32'h2;
`else
  localparam logic [31:0] RW_PRE = 32'h1;
`endif

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   clear_req;
  logic                   busy;
  logic                   wr_en;
  logic [W/8-1:0]         wr_byte_en;
  logic [AW-1:0]          wr_addr;
  logic [W-1:0]           wr_data;
  logic [NP-1:0][AW-1:0]  rd_addr;
  logic [NP-1:0][W-1:0]   rd_data;

  lut_ram_mp #(.LUT_WIDTH(W), .LUT_DEPTH(D), .NUM_RD_PORTS(NP)) dut (
    .clk        (clk),
    .rst        (rst),
    .clear_req  (clear_req),
    .busy       (busy),
    .wr_en      (wr_en),
    .wr_byte_en (wr_byte_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data)
  );

  always #5 clk = ~clk;

  logic [W-1:0] ref_mem [D];
  int           m_left;
  int           vectors = 0;
  int           miscompares = 0;
  logic [W-1:0] exp_q [$];
  int           n;

  function automatic logic [W-1:0] merge(input logic [W-1:0] old_v,
                                         input logic [W-1:0] new_v,
                                         input logic [W/8-1:0] be);
    logic [W-1:0] v;
    v = old_v;
    for (int b = 0; b < W/8; b++)
      if (be[b]) v[8*b +: 8] = new_v[8*b +: 8];
    return v;
  endfunction

  function automatic logic [W-1:0] exp_rd(input logic [AW-1:0] a);
    logic [W-1:0] v;
    if (m_left > 0) return '0;
    v = ref_mem[a];
`ifdef LUT_RAM_WR_BYPASS_EN
    if (wr_en && a == wr_addr) v = merge(v, wr_data, wr_byte_en);
`endif
    return v;
  endfunction

  task automatic cmp(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One rising edge; the model consumes the same inputs the DUT sampled.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_left = D;
    end else if (m_left > 0) begin
      ref_mem[D - m_left] = '0;
      m_left--;
    end else begin
      if (wr_en) ref_mem[wr_addr] = merge(ref_mem[wr_addr], wr_data, wr_byte_en);
      if (clear_req) m_left = D;
    end
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [W-1:0] d, input logic [W/8-1:0] be);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_byte_en = be;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic drive_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rd_addr[0] = a0;
    rd_addr[1] = a1;
    exp_q.push_back(exp_rd(a0));
    exp_q.push_back(exp_rd(a1));
  endtask

  task automatic check_rd(input string tag);
    #1;
    cmp({tag, "_p0"}, rd_data[0], exp_q.pop_front());
    cmp({tag, "_p1"}, rd_data[1], exp_q.pop_front());
  endtask

  task automatic check_busy(input string tag);
    cmp(tag, {31'b0, busy}, {31'b0, (m_left > 0)});
  endtask

  initial begin
    rst = 1'b1; clear_req = 1'b0; wr_en = 1'b0; wr_byte_en = '0;
    wr_addr = '0; wr_data = '0; rd_addr = '0; m_left = D;
    tick();
    tick();
    check_busy("rst_busy");
    drive_rd(0, 5);
    check_rd("rst_rd");

    // Power-on clear, with a write to addr 5 attempted mid-clear.
    rst = 1'b0;
    n = 0;
    while (busy && n < 400) begin
      if (n == 10) begin
        wr_en = 1'b1; wr_addr = 8'd5; wr_data = 32'hDEADBEEF; wr_byte_en = 4'hF;
      end
      if (n == 13) wr_en = 1'b0;
      drive_rd(8'(n), 8'd5);
      check_rd("clr_rd");
      tick();
      n++;
    end
    wr_en = 1'b0;
    cmp("clr_len", 32'(n), 32'd256);
    check_busy("clr_done");
    for (int a = 0; a < D; a += 2) begin
      drive_rd(8'(a), 8'(a + 1));
      check_rd("sweep");
    end
    drive_rd(5, 5);
    check_rd("wr_busy_drop");
    cmp("wr_busy_drop_lit", rd_data[0], 32'h0);

    // Byte mask.
    wr(7, 32'h11223344, 4'hF);
    wr(7, 32'hAABBCCDD, 4'b0101);
    drive_rd(7, 7);
    check_rd("bytemask");
    cmp("bytemask_lit", rd_data[1], 32'h11BB33DD);

    // Independent ports and aliased address.
    wr(10, 32'hA, 4'hF);
    wr(20, 32'hB, 4'hF);
    drive_rd(10, 20);
    check_rd("dual");
    drive_rd(8'(300), 10);
    check_rd("dual_alias");
    cmp("dual_alias_lit", rd_data[1], 32'hA);
    wr(10, 32'hFFFFFFFF, 4'h0);
    drive_rd(10, 20);
    check_rd("be_zero");
    cmp("be_zero_lit", rd_data[0], 32'hA);

    // Same-cycle read/write.
    wr(3, 32'h1, 4'hF);
    wr_en = 1'b1; wr_addr = 8'd3; wr_data = 32'h2; wr_byte_en = 4'hF;
    drive_rd(3, 3);
    check_rd("rw_pre");
    cmp("rw_pre_lit", rd_data[0], RW_PRE);
    tick();
    wr_en = 1'b0;
    drive_rd(3, 3);
    check_rd("rw_post");
    cmp("rw_post_lit", rd_data[1], 32'h2);

    // clear_req in IDLE together with a write; a second request mid-clear is ignored.
    wr(9, 32'h55, 4'hF);
    clear_req = 1'b1;
    wr_en = 1'b1; wr_addr = 8'd11; wr_data = 32'h77; wr_byte_en = 4'hF;
    drive_rd(9, 11);
    check_rd("clrreq_pre");
    tick();
    clear_req = 1'b0;
    wr_en = 1'b0;
    check_busy("clrreq_busy");
    n = 0;
    while (busy && n < 400) begin
      clear_req = (n == 50);
      tick();
      n++;
    end
    clear_req = 1'b0;
    cmp("clrreq_len", 32'(n), 32'd256);
    drive_rd(9, 11);
    check_rd("clrreq_post");
    cmp("clrreq_post_lit", rd_data[1], 32'h0);

    // Reset at clear cycle 100 restarts the full sequence.
    wr(9, 32'h55, 4'hF);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    for (int i = 0; i < 100; i++) tick();
    check_busy("mid_clear");
    rst = 1'b1;
    m_left = D;
    #1;
    check_busy("rst_mid");
    tick();
    rst = 1'b0;
    n = 0;
    while (busy && n < 400) begin
      tick();
      n++;
    end
    cmp("restart_len", 32'(n), 32'd256);
    check_busy("restart_done");
    drive_rd(9, 7);
    check_rd("restart_rd");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
